// File: rtl/weight_fifo_pkg.sv
// Types and default geometry shared by the weight FIFO load (input) and
// drain (output) controllers.
package weight_fifo_pkg;

  localparam int DEF_FIFO_WIDTH = 16;
  localparam int DEF_FIFO_DEPTH = 16;
  localparam int DEF_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FULL = 2'd2
  } fifo_state_e;

endpackage

// File: rtl/fifo_in_ctrl.sv
// Load-side controller for the weight FIFOs: streams FIFO_DEPTH source rows
// into FIFO_WIDTH parallel lanes, then holds the image until the drain releases it.
module fifo_in_ctrl
  import weight_fifo_pkg::*;
#(
  parameter int  FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int  FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int  DATA_WIDTH = DEF_DATA_WIDTH,
  localparam int ROW_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           start,
  input  logic                           abort,
  input  logic                           in_valid,
  input  logic [FIFO_WIDTH*DATA_WIDTH-1:0] in_data,
  output logic                           in_ready,
  output logic [FIFO_WIDTH-1:0]          fifo_wen,
  output logic [FIFO_WIDTH*DATA_WIDTH-1:0] fifo_wdata,
  output logic [ROW_W-1:0]               wr_row,
  // release is a reserved word, so the drain-side handshake is release_img.
  input  logic                           release_img,
  output logic                           loaded,
  output logic                           busy
);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(FIFO_DEPTH - 1);

  fifo_state_e      state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             handshake;

  // Status decoded from registered state only, keeping inputs off the ready path.
  assign in_ready = (state_q == LOAD);
  assign busy     = (state_q == LOAD);
  assign loaded   = (state_q == FULL);

  assign handshake  = in_valid && in_ready && !abort;
  assign fifo_wen   = {FIFO_WIDTH{handshake}};
  assign fifo_wdata = in_data;
  assign wr_row     = row_q;

  always_comb begin
    // NOTE: defaults first so every path assigns both signals; no latch inferred.
    state_d = state_q;
    row_d   = row_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          row_d   = '0;
        end
      end
      LOAD: begin
        if (abort) begin
          state_d = IDLE;
          row_d   = '0;
        end else if (handshake) begin
          if (row_q == LAST_ROW) begin
            state_d = FULL;
            row_d   = '0;
          end else begin
            row_d = row_q + ROW_W'(1);
          end
        end
      end
      FULL: begin
        // A simultaneous start is dropped; a fresh pulse is needed from IDLE.
        if (release_img) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        row_d   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // sample pre-edge values together.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
    end
  end

endmodule

// File: tb/tb_fifo_in_ctrl.sv
// Randomized self-checking bench for fifo_in_ctrl: default 16x16x8 instance
// against a row-counting reference model, plus a 4-lane, 2-row instance.
module tb_fifo_in_ctrl;
  import weight_fifo_pkg::*;

  localparam int W   = 16;
  localparam int D   = 16;
  localparam int DW  = 8;
  localparam int RW  = $clog2(D) + 1;
  localparam int SW  = 4;
  localparam int SD  = 2;
  localparam int SRW = $clog2(SD) + 1;
  localparam int VW  = 3 + RW + W;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic            start, abort, in_valid, release_img;
  logic [W*DW-1:0] in_data;
  logic            in_ready, loaded, busy;
  logic [W-1:0]    fifo_wen;
  logic [W*DW-1:0] fifo_wdata;
  logic [RW-1:0]   wr_row;

  logic             s_start, s_abort, s_valid, s_rel;
  logic [SW*DW-1:0] s_data;
  logic             s_ready, s_loaded, s_busy;
  logic [SW-1:0]    s_wen;
  logic [SW*DW-1:0] s_wdata;
  logic [SRW-1:0]   s_row;

  fifo_in_ctrl #(.FIFO_WIDTH(W), .FIFO_DEPTH(D), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .fifo_wen(fifo_wen),
    .fifo_wdata(fifo_wdata), .wr_row(wr_row), .release_img(release_img),
    .loaded(loaded), .busy(busy)
  );

  fifo_in_ctrl #(.FIFO_WIDTH(SW), .FIFO_DEPTH(SD), .DATA_WIDTH(DW)) dut_small (
    .clk(clk), .rstn(rstn), .start(s_start), .abort(s_abort), .in_valid(s_valid),
    .in_data(s_data), .in_ready(s_ready), .fifo_wen(s_wen),
    .fifo_wdata(s_wdata), .wr_row(s_row), .release_img(s_rel),
    .loaded(s_loaded), .busy(s_busy)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: whether a load is running, whether an image is held,
  // and how many rows the current load has accepted.
  bit m_loading, m_full;
  int m_rows;

  wire [VW-1:0] obs_vec = {in_ready, busy, loaded, wr_row, fifo_wen};

  function automatic bit exp_write();
    return m_loading && in_valid && !abort;
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    logic w;
    w = exp_write();
    return {m_loading, m_loading, m_full, RW'(m_rows), {W{w}}};
  endfunction

  task automatic model_reset();
    m_loading = 1'b0;
    m_full    = 1'b0;
    m_rows    = 0;
  endtask

  task automatic model_step();
    if (m_loading) begin
      if (abort) begin
        m_loading = 1'b0;
        m_rows    = 0;
      end else if (in_valid) begin
        m_rows++;
        if (m_rows == D) begin
          m_loading = 1'b0;
          m_full    = 1'b1;
          m_rows    = 0;
        end
      end
    end else if (m_full) begin
      if (release_img) m_full = 1'b0;
    end else if (start) begin
      m_loading = 1'b1;
      m_rows    = 0;
    end
  endtask

  task automatic drive(input bit st, input bit ab, input bit v, input bit rl);
    @(negedge clk);
    start       = st;
    abort       = ab;
    in_valid    = v;
    release_img = rl;
    for (int k = 0; k < W*DW/32; k++) in_data[k*32 +: 32] = $urandom();
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    start = 0; abort = 0; in_valid = 0; release_img = 0; in_data = '0;
    s_start = 0; s_abort = 0; s_valid = 0; s_rel = 0; s_data = '0;
    model_reset();
    #12;
    checks++;
    if (obs_vec !== '0) begin
      failures++;
      $display("FAIL reset_hold got=%h exp=0", obs_vec);
    end
    @(negedge clk);
    rstn = 1'b1;
    #1;
    checks++;
    if (obs_vec !== '0 || s_ready !== 1'b0 || s_wen !== '0) begin
      failures++;
      $display("FAIL reset_after got=%h exp=0", obs_vec);
    end
  endtask

  task automatic test_full_load();
    int writes = 0;
    drive(1, 0, 0, 0);
    tick();
    for (int i = 0; i < D; i++) begin
      drive(0, 0, 1, 0);
      checks++;
      if (obs_vec !== exp_vec() || wr_row !== RW'(i) || fifo_wen !== {W{1'b1}}) begin
        failures++;
        $display("FAIL full_load cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec());
      end
      checks++;
      if (fifo_wdata !== in_data) begin
        failures++;
        $display("FAIL full_load_data cyc=%0d got=%h exp=%h", i, fifo_wdata, in_data);
      end
      if (fifo_wen[0]) writes++;
      tick();
    end
    drive(0, 0, 1, 0);
    checks++;
    if (loaded !== 1'b1 || busy !== 1'b0 || fifo_wen !== '0 || writes != D) begin
      failures++;
      $display("FAIL full_load_end loaded=%b busy=%b writes=%0d exp 1/0/%0d", loaded, busy, writes, D);
    end
    tick();
  endtask

  task automatic test_toggle();
    int rows[$];
    drive(0, 0, 0, 1);
    tick();
    drive(1, 0, 0, 0);
    tick();
    for (int i = 0; i < 2*D; i++) begin
      drive(0, 0, (i % 2) == 0, 0);
      checks++;
      if (obs_vec !== exp_vec()) begin
        failures++;
        $display("FAIL toggle cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec());
      end
      if (fifo_wen[0]) rows.push_back(int'(wr_row));
      tick();
    end
    drive(0, 0, 0, 0);
    checks++;
    if (loaded !== 1'b1 || rows.size() != D) begin
      failures++;
      $display("FAIL toggle_end loaded=%b writes=%0d exp 1/%0d", loaded, rows.size(), D);
    end
    foreach (rows[k]) begin
      checks++;
      if (rows[k] != k) begin
        failures++;
        $display("FAIL toggle_order idx=%0d got=%0d exp=%0d", k, rows[k], k);
      end
    end
    tick();
  endtask

  task automatic test_abort();
    int  rows[$];
    bit  done = 0;
    drive(0, 0, 0, 1);
    tick();
    drive(1, 0, 0, 0);
    tick();
    for (int i = 0; i < 7; i++) begin
      drive(0, 0, 1, 0);
      tick();
    end
    drive(0, 1, 1, 0);
    checks++;
    if (wr_row !== RW'(7) || fifo_wen !== '0 || obs_vec !== exp_vec()) begin
      failures++;
      $display("FAIL abort_cycle row=%0d wen=%h exp row 7 wen 0", wr_row, fifo_wen);
    end
    tick();
    drive(0, 0, 1, 0);
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || wr_row !== '0 || fifo_wen !== '0) begin
      failures++;
      $display("FAIL abort_idle got=%h exp busy/ready/row/wen all 0", obs_vec);
    end
    tick();
    drive(1, 0, 0, 0);
    tick();
    for (int i = 0; i < 200 && !done; i++) begin
      drive(0, 0, $urandom_range(1, 0) == 1, 0);
      checks++;
      if (obs_vec !== exp_vec()) begin
        failures++;
        $display("FAIL abort_reload cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec());
      end
      if (fifo_wen[0]) rows.push_back(int'(wr_row));
      if (loaded) done = 1;
      else tick();
    end
    checks++;
    if (!done || rows.size() != D) begin
      failures++;
      $display("FAIL abort_reload_end done=%b writes=%0d exp 1/%0d", done, rows.size(), D);
    end
    foreach (rows[k]) begin
      checks++;
      if (rows[k] != k) begin
        failures++;
        $display("FAIL abort_reload_order idx=%0d got=%0d exp=%0d", k, rows[k], k);
      end
    end
    tick();
  endtask

  task automatic test_full_hold();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, $urandom_range(1, 0) == 1, 0);
      checks++;
      if (loaded !== 1'b1 || busy !== 1'b0 || fifo_wen !== '0) begin
        failures++;
        $display("FAIL full_start_ignored cyc=%0d loaded=%b busy=%b exp 1/0", i, loaded, busy);
      end
      tick();
    end
    drive(0, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0);
    checks++;
    if (loaded !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL full_release loaded=%b busy=%b exp 0/0", loaded, busy);
    end
    tick();
    drive(1, 0, 0, 0);
    tick();
    for (int i = 0; i < D; i++) begin
      drive(0, 0, 1, 0);
      tick();
    end
    drive(1, 0, 0, 1);
    checks++;
    if (loaded !== 1'b1) begin
      failures++;
      $display("FAIL full_reloaded loaded=%b exp 1", loaded);
    end
    tick();
    drive(0, 0, 1, 0);
    checks++;
    if (loaded !== 1'b0 || busy !== 1'b0 || fifo_wen !== '0 || obs_vec !== exp_vec()) begin
      failures++;
      $display("FAIL start_release got=%h exp=%h", obs_vec, exp_vec());
    end
    tick();
  endtask

  task automatic test_async_reset();
    int writes = 0;
    drive(1, 0, 0, 0);
    tick();
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 1, 0);
      tick();
    end
    drive(0, 0, 1, 0);
    checks++;
    if (wr_row !== RW'(10) || fifo_wen !== {W{1'b1}}) begin
      failures++;
      $display("FAIL pre_reset row=%0d wen=%h exp 10/ffff", wr_row, fifo_wen);
    end
    #1 rstn = 1'b0;
    #1;
    checks++;
    if (obs_vec !== '0) begin
      failures++;
      $display("FAIL async_reset got=%h exp=0", obs_vec);
    end
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    drive(1, 0, 0, 0);
    tick();
    for (int i = 0; i < D; i++) begin
      drive(0, 0, 1, 0);
      checks++;
      if (obs_vec !== exp_vec()) begin
        failures++;
        $display("FAIL post_reset_load cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec());
      end
      if (fifo_wen[0]) writes++;
      tick();
    end
    drive(0, 0, 0, 0);
    checks++;
    if (loaded !== 1'b1 || writes != D) begin
      failures++;
      $display("FAIL post_reset_end loaded=%b writes=%0d exp 1/%0d", loaded, writes, D);
    end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(3, 0) == 0, $urandom_range(15, 0) == 0,
            $urandom_range(1, 0) == 1, $urandom_range(3, 0) == 0);
      checks++;
      if (obs_vec !== exp_vec()) begin
        failures++;
        $display("FAIL random cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec());
      end
      if (exp_write()) begin
        checks++;
        if (fifo_wdata !== in_data) begin
          failures++;
          $display("FAIL random_data cyc=%0d", i);
        end
      end
      tick();
    end
  endtask

  task automatic test_small();
    logic [DW-1:0] lanes [SW];
    int            writes = 0;
    @(negedge clk);
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    s_valid = 1'b1;
    for (int r = 0; r < SD; r++) begin
      for (int l = 0; l < SW; l++) begin
        lanes[l] = DW'($urandom());
        s_data[l*DW +: DW] = lanes[l];
      end
      #1;
      checks++;
      if (s_wen !== {SW{1'b1}} || s_row !== SRW'(r) || s_loaded !== 1'b0) begin
        failures++;
        $display("FAIL small_write r=%0d wen=%h row=%0d loaded=%b", r, s_wen, s_row, s_loaded);
      end
      for (int l = 0; l < SW; l++) begin
        checks++;
        if (s_wdata[l*DW +: DW] !== lanes[l]) begin
          failures++;
          $display("FAIL small_lane r=%0d lane=%0d got=%h exp=%h", r, l, s_wdata[l*DW +: DW], lanes[l]);
        end
      end
      if (s_wen[0]) writes++;
      @(negedge clk);
    end
    #1;
    checks++;
    if (s_loaded !== 1'b1 || s_wen !== '0 || s_ready !== 1'b0 || writes != SD) begin
      failures++;
      $display("FAIL small_loaded loaded=%b wen=%h writes=%0d exp 1/0/%0d", s_loaded, s_wen, writes, SD);
    end
    s_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_toggle();
    test_abort();
    test_full_hold();
    test_async_reset();
    test_random();
    test_small();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_in_ctrl.md
FIFO_IN_CTRL -- requirements
Module: fifo_in_ctrl

Interface
REQ-001 SHALL have parameter FIFO_WIDTH, default 16: number of parallel weight FIFO lanes.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16: rows per load, FIFO_DEPTH >= 2.
REQ-003 SHALL have parameter DATA_WIDTH, default 8: bits per lane entry.
REQ-004 SHALL use derived ROW_W = $clog2(FIFO_DEPTH) + 1.
REQ-005 SHALL provide clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL provide rstn  input  1  reset, asynchronous, active-low.
REQ-007 SHALL provide start  input  1  begin loading one full FIFO image.
REQ-008 SHALL provide abort  input  1  cancel an in-progress load.
REQ-009 SHALL provide in_valid  input  1  source row valid.
REQ-010 SHALL provide in_data  input  FIFO_WIDTH*DATA_WIDTH  source row, lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-011 SHALL provide in_ready  output  1  block accepts a row this cycle.
REQ-012 SHALL provide fifo_wen  output  FIFO_WIDTH  per-lane FIFO write enable.
REQ-013 SHALL provide fifo_wdata  output  FIFO_WIDTH*DATA_WIDTH  per-lane FIFO write data.
REQ-014 SHALL provide wr_row  output  ROW_W  index of row being written.
REQ-015 SHALL provide release  input  1  drain side has taken the image; FIFOs free.
REQ-016 SHALL provide loaded  output  1  FIFOs hold a complete image.
REQ-017 SHALL provide busy  output  1  load in progress.

Function
REQ-018 SHALL implement FSM states IDLE, LOAD, FULL.
REQ-019 IDLE: start=1 -> LOAD, row_cnt <= 0; abort and release ignored.
REQ-020 LOAD: in_ready=1, busy=1; handshake = in_valid && in_ready && !abort.
REQ-021 LOAD handshake: row_cnt <= row_cnt+1; handshake with row_cnt == FIFO_DEPTH-1 -> FULL, row_cnt <= 0.
REQ-022 LOAD with abort=1 -> IDLE, row_cnt <= 0, no write that cycle even if in_valid=1.
REQ-023 FULL: loaded=1, in_ready=0; release=1 -> IDLE next cycle.
REQ-024 start SHALL be ignored in LOAD and FULL; start and release together in FULL -> IDLE only; a new start pulse is required.
REQ-025 fifo_wen SHALL equal {FIFO_WIDTH{handshake}}, combinational, zero latency.
REQ-026 fifo_wdata SHALL equal in_data combinationally; value is don't-care when fifo_wen=0.
REQ-027 wr_row SHALL equal row_cnt; rows written strictly in order 0..FIFO_DEPTH-1.
REQ-028 in_valid low during LOAD SHALL stall without state change; no bubble limit.
REQ-029 in_ready, busy, loaded SHALL be decoded from registered state only (no input-to-ready path).
REQ-030 Exactly FIFO_DEPTH writes SHALL occur per completed load; no write outside LOAD.

Reset
REQ-031 rstn low SHALL asynchronously force state IDLE, row_cnt 0.
REQ-032 During and after reset: in_ready=0, fifo_wen=0, wr_row=0, loaded=0, busy=0.
REQ-033 Reset mid-LOAD SHALL discard partial load; the FIFO image is invalid and requires a fresh start.

Structure
REQ-034 A shared weight_fifo package SHALL hold the state enum type and default FIFO_WIDTH/FIFO_DEPTH/DATA_WIDTH constants, shared with the drain-side controller.
REQ-035 The block SHALL be a single module with no sub-modules; row counter and FSM inline.

Verification
REQ-036 Reset then start, in_valid held 1 for 16 cycles -> fifo_wen=all-ones on cycles 1..16 with wr_row 0..15, loaded=1 on cycle 17, busy=0.
REQ-037 Load with in_valid toggling 1/0 -> 16 writes over 32 cycles, wr_row increments only on writes, no duplicated or skipped row.
REQ-038 abort asserted at wr_row=7 with in_valid=1 -> no write that cycle, IDLE next cycle, wr_row=0; new start reloads rows 0..15.
REQ-039 In FULL, start pulses -> ignored, loaded stays 1; release -> loaded=0 next cycle; start+release same cycle -> IDLE, no LOAD.
REQ-040 rstn asserted asynchronously at wr_row=10 -> in_ready and fifo_wen drop immediately, all outputs zero; post-reset start yields full 16-row load.
REQ-041 FIFO_DEPTH=2, FIFO_WIDTH=4 instance -> exactly 2 writes, loaded on third cycle, lane data mapping matches in_data slices.
